// File: rtl/axis_bram_line_seq.sv
// Line sequencer between AXIS word streams and a WORDS x 32b wide-BRAM line buffer.
// Optional committed-line counter output lines_wr: define AXIS_BRAM_SEQ_LINECNT_EN.
module axis_bram_line_seq #(
  parameter int ADDR_W = 12,
  parameter int WORDS  = 36,
  parameter int PTR_W  = 6,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mode_rw,
  input  logic [ADDR_W-1:0] rd_start_addr,
  input  logic [ADDR_W-1:0] rd_line_count,
  input  logic              start,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_accep,
  output logic              wr_load,
  output logic [PTR_W-1:0]  wr_sel,
  output logic              buf_cap,
  output logic              out_valid,
  output logic [PTR_W-1:0]  out_sel,
  output logic              out_last,
  input  logic              out_accep,
  output logic              bram_en,
  output logic              bram_wen,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              busy,
  output logic              done
`ifdef AXIS_BRAM_SEQ_LINECNT_EN
  ,
  output logic [ADDR_W:0]   lines_wr
`endif
);

  typedef enum logic [2:0] {
    IDLE, FILL, COMMIT, RD_REQ, RD_WAIT, DRAIN, DONE
  } state_t;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WORDS - 1);
  localparam logic [2:0]       LAT_LAST = 3'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] ONE_LINE = ADDR_W'(1);

  state_t state, state_n;
  logic [PTR_W-1:0]  ptr, ptr_n;
  logic [ADDR_W-1:0] wr_addr, wr_addr_n;
  logic [ADDR_W-1:0] rd_addr, rd_addr_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [2:0]        lat, lat_n;

  logic ptr_end, fill_hold, wait_end, final_line;
  logic take_in, take_out;

  assign ptr_end    = ptr == PTR_LAST;
  assign wait_end   = lat == LAT_LAST;
  assign final_line = cnt == ONE_LINE;
  // Leave FILL only on a line boundary, so a mid-line mode change waits.
  assign fill_hold  = (ptr == '0) && !mode_rw;
  assign take_in    = in_valid && in_accep;
  assign take_out   = out_valid && out_accep;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      ptr     <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
      cnt     <= '0;
      lat     <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      wr_addr <= wr_addr_n;
      rd_addr <= rd_addr_n;
      cnt     <= cnt_n;
      lat     <= lat_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    wr_addr_n = wr_addr;
    rd_addr_n = rd_addr;
    cnt_n     = cnt;
    lat_n     = lat;
    unique case (state)
      IDLE: begin
        if (mode_rw) begin
          state_n   = FILL;
          wr_addr_n = '0;
        end else if (start) begin
          if (rd_line_count != '0) begin
            state_n   = RD_REQ;
            rd_addr_n = rd_start_addr;
            cnt_n     = rd_line_count;
          end else begin
            state_n = DONE;
          end
        end
      end
      FILL: begin
        if (fill_hold) begin
          state_n = IDLE;
        end else if (take_in) begin
          if (ptr_end || in_last) begin
            state_n = COMMIT;
            ptr_n   = '0;
          end else begin
            ptr_n = ptr + 1'b1;
          end
        end
      end
      COMMIT: begin
        wr_addr_n = wr_addr + 1'b1;
        state_n   = FILL;
      end
      RD_REQ: begin
        lat_n   = '0;
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_end) state_n = DRAIN;
        else          lat_n   = lat + 1'b1;
      end
      DRAIN: begin
        if (take_out) begin
          if (ptr_end) begin
            ptr_n     = '0;
            rd_addr_n = rd_addr + 1'b1;
            cnt_n     = cnt - 1'b1;
            state_n   = final_line ? DONE : RD_REQ;
          end else begin
            ptr_n = ptr + 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_accep  = 1'b0;
    wr_load   = 1'b0;
    wr_sel    = '0;
    buf_cap   = 1'b0;
    out_valid = 1'b0;
    out_sel   = '0;
    out_last  = 1'b0;
    bram_en   = 1'b0;
    bram_wen  = 1'b0;
    bram_addr = '0;
    done      = 1'b0;
    busy      = state != IDLE;
    unique case (state)
      FILL: begin
        in_accep = !fill_hold;
        wr_load  = in_valid && !fill_hold;
        wr_sel   = ptr;
      end
      COMMIT: begin
        bram_en   = 1'b1;
        bram_wen  = 1'b1;
        bram_addr = wr_addr;
      end
      RD_REQ: begin
        bram_en   = 1'b1;
        bram_addr = rd_addr;
      end
      RD_WAIT: buf_cap = wait_end;
      DRAIN: begin
        out_valid = 1'b1;
        out_sel   = ptr;
        out_last  = ptr_end && final_line;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

`ifdef AXIS_BRAM_SEQ_LINECNT_EN
  always_ff @(posedge clk) begin
    if (!rstn)
      lines_wr <= '0;
    else if (state == COMMIT && lines_wr != '1)
      lines_wr <= lines_wr + 1'b1;
  end
`endif

endmodule
